// File: rtl/uc_secuencial.sv
// Sequencing control unit for the single-cycle microcontroller datapath.
// Decodes opcode/z into datapath selects inside a run/halt/fault state machine.
module uc_secuencial #(
    parameter int ICW              = 16,
    parameter bit FAULT_ON_ILLEGAL = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [5:0]     opcode,
    input  logic           z,
    output logic           s_inc,
    output logic           s_inc2,
    output logic           s_inm,
    output logic           we3,
    output logic [2:0]     op,
    output logic           rst_dp,
    output logic           running,
    output logic           halted,
    output logic           fault,
    output logic [ICW-1:0] icount
);
    localparam logic [5:0] OP_LDI  = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_BR   = 6'b010100;
    localparam logic [5:0] OP_NOP  = 6'b111110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {IDLE, RUN, HALTED, FAULT, RESTART} state_t;

    state_t state;
    state_t next_state;
    logic   is_alu;
    logic   is_halt;
    logic   is_illegal;
    logic   retire;

    always_comb begin
        is_alu     = (opcode[5:3] == 3'b000);
        is_halt    = (opcode == OP_HALT);
        is_illegal = !(is_alu || (opcode inside {OP_LDI, OP_J, OP_JZ, OP_JNZ,
                                                 OP_BR, OP_NOP, OP_HALT}));
        retire     = (state == RUN) && !is_halt && !is_illegal;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN: begin
                if (is_halt)
                    next_state = HALTED;
                else if (is_illegal && FAULT_ON_ILLEGAL)
                    next_state = FAULT;
            end
            HALTED,
            FAULT:   if (start) next_state = RESTART;
            RESTART: next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Outputs follow state combinationally, so an async reset drops them to the safe set at once
    always_comb begin
        rst_dp = 1'b1;
        we3    = 1'b0;
        s_inc  = 1'b1;
        s_inc2 = 1'b0;
        s_inm  = 1'b0;
        op     = 3'b000;
        case (state)
            RUN: begin
                rst_dp = 1'b0;
                if (is_alu) begin
                    we3 = 1'b1;
                    op  = opcode[2:0];
                end else begin
                    case (opcode)
                        OP_LDI: begin
                            we3   = 1'b1;
                            s_inm = 1'b1;
                        end
                        OP_J:    s_inc  = 1'b0;
                        OP_JZ:   s_inc  = ~z;
                        OP_JNZ:  s_inc  = z;
                        OP_BR,
                        OP_HALT: s_inc2 = 1'b1;
                        default: ;
                    endcase
                end
            end
            HALTED: begin
                rst_dp = 1'b0;
                s_inc2 = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter is also cleared on entry to RESTART so it already reads 0 during that cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            icount  <= '0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
            halted  <= (next_state == HALTED);
            fault   <= (next_state == FAULT);
            if (state == IDLE || state == RESTART || next_state == RESTART)
                icount <= '0;
            else if (retire && icount != '1)
                icount <= icount + ICW'(1);
        end
    end
endmodule
